saber_hit_arbiter: RTL and testbench

Two-player, frame-synchronous saber hit arbiter for the fencing game. Once per video frame it snapshots both fencers' positions and attack/block states, tests range with parametrised reach, and requires a collision to persist before scoring. It allows one hit per attack, resolves simultaneous hits as a double hit, and enforces a post-hit cooldown. It sits between the pose/tracking front end and the score/game-state logic in the pixel clock domain.

---
 rtl/saber_hit_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_saber_hit_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/saber_hit_arbiter.sv
// Frame-synchronous two-fencer hit arbiter: range test, hold persistence, one hit per attack, cooldown.
// Latency: hit/parry pulses two cycles after frame_in. Optional parry detection under SABER_PARRY_EN.
module saber_hit_arbiter #(
   parameter int X_W             = 11,
   parameter int Y_W             = 10,
   parameter int REACH_X         = 64,
   parameter int REACH_Y         = 48,
   parameter int HOLD_FRAMES     = 2,
   parameter int COOLDOWN_FRAMES = 30
) (
   input  logic           clk_pixel_in,
   input  logic           rst_n_in,
   input  logic           frame_in,
   input  logic [X_W-1:0] a_x,
   input  logic [X_W-1:0] b_x,
   input  logic [Y_W-1:0] a_y,
   input  logic [Y_W-1:0] b_y,
   input  logic           a_attacking,
   input  logic           b_attacking,
   input  logic           a_blocking,
   input  logic           b_blocking,
   output logic           a_hit,
   output logic           b_hit,
   output logic           double_hit,
   output logic           a_colliding,
   output logic           b_colliding,
   output logic           busy,
   output logic           a_parry,
   output logic           b_parry
);
   typedef enum logic [1:0] {IDLE, CALC, DECIDE, COOLDOWN} state_t;

   localparam logic signed [X_W:0] REACH_XS = (X_W+1)'(REACH_X);
   localparam logic signed [Y_W:0] REACH_YS = (Y_W+1)'(REACH_Y);
   localparam logic [3:0]          HOLD     = 4'(HOLD_FRAMES);
   localparam logic [7:0]          COOL     = 8'(COOLDOWN_FRAMES);

   state_t         state_q;
   logic [X_W-1:0] ax_q, bx_q;
   logic [Y_W-1:0] ay_q, by_q;
   logic           aatt_q, batt_q, ablk_q, bblk_q;
   logic           prev_a_q, prev_b_q, prev_vld_q;
   logic           armed_a_q, armed_b_q;
   logic [3:0]     cnt_a_q, cnt_b_q;
   logic [7:0]     cd_q;

   logic signed [X_W:0] diff_x, dx;
   logic signed [Y_W:0] diff_y, dy;
   logic                in_range, a_qual, b_qual, a_score, b_score;
   logic                armed_a_d, armed_b_d;

   // Widened by one bit so the subtraction cannot wrap at the screen edges.
   always_comb begin
      diff_x    = $signed({1'b0, ax_q}) - $signed({1'b0, bx_q});
      diff_y    = $signed({1'b0, ay_q}) - $signed({1'b0, by_q});
      dx        = diff_x[X_W] ? -diff_x : diff_x;
      dy        = diff_y[Y_W] ? -diff_y : diff_y;
      in_range  = (dx <= REACH_XS) && (dy <= REACH_YS);
      a_qual    = in_range & aatt_q & ~bblk_q;
      b_qual    = in_range & batt_q & ~ablk_q;
      a_score   = (cnt_a_q == HOLD) & armed_a_q;
      b_score   = (cnt_b_q == HOLD) & armed_b_q;
      // prev_vld_q stops an attack held across reset from arming on the first frame.
      armed_a_d = armed_a_q | (a_attacking & prev_vld_q & ~prev_a_q);
      armed_b_d = armed_b_q | (b_attacking & prev_vld_q & ~prev_b_q);
   end

`ifdef SABER_PARRY_EN
   logic a_blkd_q, b_blkd_q;
`else
   assign a_parry = 1'b0;
   assign b_parry = 1'b0;
`endif

   always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q     <= IDLE;
         ax_q        <= '0;
         bx_q        <= '0;
         ay_q        <= '0;
         by_q        <= '0;
         aatt_q      <= 1'b0;
         batt_q      <= 1'b0;
         ablk_q      <= 1'b0;
         bblk_q      <= 1'b0;
         prev_a_q    <= 1'b0;
         prev_b_q    <= 1'b0;
         prev_vld_q  <= 1'b0;
         armed_a_q   <= 1'b0;
         armed_b_q   <= 1'b0;
         cnt_a_q     <= '0;
         cnt_b_q     <= '0;
         cd_q        <= '0;
         a_hit       <= 1'b0;
         b_hit       <= 1'b0;
         double_hit  <= 1'b0;
         a_colliding <= 1'b0;
         b_colliding <= 1'b0;
         busy        <= 1'b0;
`ifdef SABER_PARRY_EN
         a_blkd_q    <= 1'b0;
         b_blkd_q    <= 1'b0;
         a_parry     <= 1'b0;
         b_parry     <= 1'b0;
`endif
      end else begin
         a_hit      <= 1'b0;
         b_hit      <= 1'b0;
         double_hit <= 1'b0;
`ifdef SABER_PARRY_EN
         a_parry    <= 1'b0;
         b_parry    <= 1'b0;
`endif
         case (state_q)
            IDLE: if (frame_in) begin
               ax_q       <= a_x;
               bx_q       <= b_x;
               ay_q       <= a_y;
               by_q       <= b_y;
               aatt_q     <= a_attacking;
               batt_q     <= b_attacking;
               ablk_q     <= a_blocking;
               bblk_q     <= b_blocking;
               armed_a_q  <= armed_a_d;
               armed_b_q  <= armed_b_d;
               prev_a_q   <= a_attacking;
               prev_b_q   <= b_attacking;
               prev_vld_q <= 1'b1;
               state_q    <= CALC;
            end
            CALC: begin
               a_colliding <= a_qual;
               b_colliding <= b_qual;
               cnt_a_q     <= !a_qual ? 4'd0 : (cnt_a_q == HOLD) ? HOLD : cnt_a_q + 4'd1;
               cnt_b_q     <= !b_qual ? 4'd0 : (cnt_b_q == HOLD) ? HOLD : cnt_b_q + 4'd1;
`ifdef SABER_PARRY_EN
               a_blkd_q    <= in_range & aatt_q & bblk_q;
               b_blkd_q    <= in_range & batt_q & ablk_q;
`endif
               state_q     <= DECIDE;
            end
            DECIDE: begin
               if (a_score && b_score) begin
                  double_hit <= 1'b1;
                  armed_a_q  <= 1'b0;
                  armed_b_q  <= 1'b0;
               end else begin
                  if (a_score) begin
                     a_hit     <= 1'b1;
                     armed_a_q <= 1'b0;
                  end
                  if (b_score) begin
                     b_hit     <= 1'b1;
                     armed_b_q <= 1'b0;
                  end
               end
`ifdef SABER_PARRY_EN
               // A blocked attack never qualifies, so it cannot collide with that side's score.
               if (a_blkd_q && armed_a_q) begin
                  b_parry   <= 1'b1;
                  armed_a_q <= 1'b0;
                  cnt_a_q   <= '0;
               end
               if (b_blkd_q && armed_b_q) begin
                  a_parry   <= 1'b1;
                  armed_b_q <= 1'b0;
                  cnt_b_q   <= '0;
               end
`endif
               if (a_score || b_score) begin
                  state_q <= COOLDOWN;
                  cd_q    <= COOL;
                  busy    <= 1'b1;
                  cnt_a_q <= '0;
                  cnt_b_q <= '0;
               end else begin
                  state_q <= IDLE;
               end
            end
            COOLDOWN: if (frame_in) begin
               armed_a_q <= armed_a_d;
               armed_b_q <= armed_b_d;
               prev_a_q  <= a_attacking;
               prev_b_q  <= b_attacking;
               cd_q      <= cd_q - 8'd1;
               if (cd_q == 8'd1) begin
                  state_q <= IDLE;
                  busy    <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_saber_hit_arbiter.sv
// Directed vector bench for saber_hit_arbiter (default parameters); parry expectations follow SABER_PARRY_EN.
module tb_saber_hit_arbiter;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        frame_in = 1'b0;
   logic [10:0] a_x = '0, b_x = '0;
   logic [9:0]  a_y = '0, b_y = '0;
   logic        a_att = 1'b0, b_att = 1'b0, a_blk = 1'b0, b_blk = 1'b0;
   logic        a_hit, b_hit, double_hit, a_col, b_col, busy, a_parry, b_parry;

   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   saber_hit_arbiter dut (
      .clk_pixel_in(clk), .rst_n_in(rst_n), .frame_in(frame_in),
      .a_x(a_x), .b_x(b_x), .a_y(a_y), .b_y(b_y),
      .a_attacking(a_att), .b_attacking(b_att),
      .a_blocking(a_blk), .b_blocking(b_blk),
      .a_hit(a_hit), .b_hit(b_hit), .double_hit(double_hit),
      .a_colliding(a_col), .b_colliding(b_col), .busy(busy),
      .a_parry(a_parry), .b_parry(b_parry)
   );

   // outs packing: {a_hit, b_hit, double_hit, busy, a_parry, b_parry}
   localparam logic [5:0] O_AHIT = 6'b100100;
   localparam logic [5:0] O_DBL  = 6'b001100;
`ifdef SABER_PARRY_EN
   localparam logic [5:0] O_BPAR = 6'b000001;
`else
   localparam logic [5:0] O_BPAR = 6'b000000;
`endif

   typedef struct {
      string       nm;
      logic [10:0] ax, bx;
      logic [9:0]  ay, by;
      logic        aatt, batt, ablk, bblk;
      logic [1:0]  col;
      logic [5:0]  outs;
      int          drain;
   } vec_t;

   function automatic vec_t mk(string nm, int ax, int ay, int bx, int by, bit aatt, bit batt,
                               bit ablk, bit bblk, logic [1:0] col, logic [5:0] outs, int drain);
      vec_t v;
      v.nm = nm; v.ax = 11'(ax); v.ay = 10'(ay); v.bx = 11'(bx); v.by = 10'(by);
      v.aatt = aatt; v.batt = batt; v.ablk = ablk; v.bblk = bblk;
      v.col = col; v.outs = outs; v.drain = drain;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b, expected %b", nm, act, exp);
   endtask

   function automatic logic [5:0] outs_now();
      return {a_hit, b_hit, double_hit, busy, a_parry, b_parry};
   endfunction

   task automatic set_in(input vec_t v);
      a_x = v.ax; b_x = v.bx; a_y = v.ay; b_y = v.by;
      a_att = v.aatt; b_att = v.batt; a_blk = v.ablk; b_blk = v.bblk;
   endtask

   // Called at a negedge; one frame occupies four cycles.
   task automatic apply(input vec_t v, input bit do_chk);
      set_in(v);
      frame_in = 1'b1;
      @(negedge clk) frame_in = 1'b0;
      @(negedge clk);
      if (do_chk) chk({v.nm, "_col"}, {6'b0, a_col, b_col}, {6'b0, v.col});
      @(negedge clk);
      if (do_chk) chk({v.nm, "_out"}, {2'b0, outs_now()}, {2'b0, v.outs});
      @(negedge clk);
      if (do_chk && (v.outs & 6'b111011) != 6'b0)
         chk({v.nm, "_pulse_w"}, {2'b0, outs_now()}, {2'b0, v.outs & 6'b000100});
   endtask

   task automatic drain(input vec_t v, input int n);
      for (int i = 0; i < n; i++) begin
         apply(v, 1'b0);
         if (i == n - 2) chk({v.nm, "_busy_held"}, {7'b0, busy}, 8'd1);
         if (i == n - 1) chk({v.nm, "_busy_fall"}, {7'b0, busy}, 8'd0);
      end
   endtask

   vec_t tbl[25];
   vec_t hv;

   initial begin
      tbl[0]  = mk("prime",     100, 200, 150, 210, 0, 0, 0, 0, 2'b00, 6'b0,   0);
      tbl[1]  = mk("a_f1",      100, 200, 150, 210, 1, 0, 0, 0, 2'b10, 6'b0,   0);
      tbl[2]  = mk("a_f2",      100, 200, 150, 210, 1, 0, 0, 0, 2'b10, O_AHIT, 30);
      tbl[3]  = mk("held1",     100, 200, 150, 210, 1, 0, 0, 0, 2'b10, 6'b0,   0);
      tbl[4]  = mk("held2",     100, 200, 150, 210, 1, 0, 0, 0, 2'b10, 6'b0,   0);
      tbl[5]  = mk("drop",      100, 200, 150, 210, 0, 0, 0, 0, 2'b00, 6'b0,   0);
      tbl[6]  = mk("rise1",     100, 200, 150, 210, 1, 0, 0, 0, 2'b10, 6'b0,   0);
      tbl[7]  = mk("rise2",     100, 200, 150, 210, 1, 0, 0, 0, 2'b10, O_AHIT, 30);
      tbl[8]  = mk("dbl_prime", 100, 200, 150, 210, 0, 0, 0, 0, 2'b00, 6'b0,   0);
      tbl[9]  = mk("dbl1",      100, 200, 150, 210, 1, 1, 0, 0, 2'b11, 6'b0,   0);
      tbl[10] = mk("dbl2",      100, 200, 150, 210, 1, 1, 0, 0, 2'b11, O_DBL,  30);
      tbl[11] = mk("dx64_prime",100, 200, 164, 200, 0, 0, 0, 0, 2'b00, 6'b0,   0);
      tbl[12] = mk("dx64_1",    100, 200, 164, 200, 1, 0, 0, 0, 2'b10, 6'b0,   0);
      tbl[13] = mk("dx64_2",    100, 200, 164, 200, 1, 0, 0, 0, 2'b10, O_AHIT, 30);
      tbl[14] = mk("dx65_prime",100, 200, 165, 200, 0, 0, 0, 0, 2'b00, 6'b0,   0);
      tbl[15] = mk("dx65_1",    100, 200, 165, 200, 1, 0, 0, 0, 2'b00, 6'b0,   0);
      tbl[16] = mk("dx65_2",    100, 200, 165, 200, 1, 0, 0, 0, 2'b00, 6'b0,   0);
      tbl[17] = mk("wrap1",       0, 200, 2047, 200, 1, 0, 0, 0, 2'b00, 6'b0,  0);
      tbl[18] = mk("wrap2",       0, 200, 2047, 200, 1, 0, 0, 0, 2'b00, 6'b0,  0);
      tbl[19] = mk("dy48_1",    500, 100, 500, 148, 1, 0, 0, 0, 2'b10, 6'b0,   0);
      tbl[20] = mk("dy48_2",    500, 100, 500, 148, 1, 0, 0, 0, 2'b10, O_AHIT, 30);
      tbl[21] = mk("blk_prime", 100, 200, 150, 210, 0, 0, 0, 0, 2'b00, 6'b0,   0);
      tbl[22] = mk("blk1",      100, 200, 150, 210, 1, 0, 0, 1, 2'b00, O_BPAR, 0);
      tbl[23] = mk("blk2",      100, 200, 150, 210, 1, 0, 0, 1, 2'b00, 6'b0,   0);
      tbl[24] = mk("unblk",     100, 200, 150, 210, 1, 0, 0, 0, 2'b10, 6'b0,   0);

      repeat (2) @(negedge clk);
      chk("reset_out", {2'b0, outs_now()}, 8'd0);
      chk("reset_col", {6'b0, a_col, b_col}, 8'd0);
      rst_n = 1'b1;
      @(negedge clk);

      foreach (tbl[i]) begin
         apply(tbl[i], 1'b1);
         if (tbl[i].drain > 0) drain(tbl[i], tbl[i].drain);
      end

      // Reset in the middle of COOLDOWN, attack held through it.
      rst_n = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      apply(tbl[0], 1'b1);
      apply(tbl[1], 1'b1);
      apply(tbl[2], 1'b1);
      repeat (3) apply(tbl[2], 1'b0);
      rst_n = 1'b0;
      #1 chk("rst_cool_out", {2'b0, outs_now()}, 8'd0);
      chk("rst_cool_col", {6'b0, a_col, b_col}, 8'd0);
      @(negedge clk) rst_n = 1'b1;
      hv = mk("post_rst_a", 100, 200, 150, 210, 1, 0, 0, 0, 2'b10, 6'b0, 0);
      apply(hv, 1'b1);
      hv.nm = "post_rst_b";
      apply(hv, 1'b1);
      apply(hv, 1'b1);

      // Reset while the arbiter is in CALC for an armed, qualifying attack.
      apply(tbl[5], 1'b1);
      apply(tbl[6], 1'b1);
      set_in(tbl[6]);
      frame_in = 1'b1;
      @(negedge clk) frame_in = 1'b0;
      rst_n = 1'b0;
      #1 chk("rst_calc_out", {2'b0, outs_now()}, 8'd0);
      chk("rst_calc_col", {6'b0, a_col, b_col}, 8'd0);
      @(negedge clk) rst_n = 1'b1;
      hv.nm = "post_calc_a";
      apply(hv, 1'b1);
      hv.nm = "post_calc_b";
      apply(hv, 1'b1);
      apply(hv, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
